rr_burst_arbiter: RTL and testbench

- Shares one downstream valid/ready stream port among N upstream requesters.
- Uses round-robin priority with burst locking.
- Once granted, a requester holds the port until it sends a beat with last=1, or until an optional fairness cap of MAX_BURST beats is reached.
- Sits in front of any single-ported shared resource (memory port, bus master, output link) where transactions must not interleave.

---
 rtl/rr_burst_arbiter.sv | 102 ++++++++++
 tb/tb_rr_burst_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N requesters with burst locking.
// Latency: grant is taken one cycle after a request in IDLE; beats then pass combinationally.
// Backpressure: out_ready feeds only the holder's in_ready; the beat counter holds while stalled.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N-1:0]                     in_valid,
  input  logic [N*W-1:0]                   in_data,
  input  logic [N-1:0]                     in_last,
  output logic [N-1:0]                     in_ready,
  output logic                             out_valid,
  output logic [W-1:0]                     out_data,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_src,
  output logic                             busy
);

  localparam int SW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (MAX_BURST > 0) ? (($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1) : 1;
  localparam int CAP_I = (MAX_BURST > 0) ? (MAX_BURST - 1) : 0;
  localparam logic [CW-1:0] CAP_LAST = CW'(CAP_I);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] win;
  logic          xfer;
  logic          release_now;

  // Rotating-priority pick: (ptr+1) mod N is highest; scan downwards so the best index is written last.
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--) begin
      if (in_valid[(int'(ptr) + k) % N]) begin
        win = SW'((int'(ptr) + k) % N);
      end
    end
  end

  // A beat moves only while locked; release on last or when the fairness cap is reached.
  always_comb begin
    xfer        = (state == LOCKED) && in_valid[g] && out_ready;
    release_now = xfer && (in_last[g] || ((MAX_BURST != 0) && (cnt == CAP_LAST)));
  end

  // Combinational grant path: the holder is muxed straight through with no per-beat latency.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    busy      = 1'b0;
    if (state == LOCKED) begin
      out_valid   = in_valid[g];
      out_data    = in_data[int'(g)*W +: W];
      out_last    = in_last[g];
      in_ready[g] = out_ready;
      out_src     = g;
      busy        = 1'b1;
    end
  end

  // Grant FSM: IDLE picks a winner, LOCKED holds it until release, then one idle bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= SW'(N - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            g     <= win;
            cnt   <= '0;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (release_now) begin
            ptr   <= g;
            cnt   <= '0;
            state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N=4, W=32, MAX_BURST=4).
// Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Expected values are hand-derived per step.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [1:0]     out_src;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_burst_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  initial begin
    int rr [6];
    rr = '{0, 1, 2, 3, 0, 1};

    // Reset with every requester asking
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    in_data   = '0;
    for (int i = 0; i < N; i++) set_lane(i, 32'hA0 + i);
    tick();
    tick();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);

    // Round-robin with single-beat bursts: 0,1,2,3,0,1 with an idle cycle between
    rst_n     = 1'b1;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      chk("rr_src",      64'(out_src),  64'(rr[i]));
      chk("rr_busy",     64'(busy),     64'd1);
      chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << rr[i]));
      chk("rr_data",     64'(out_data), 64'(32'hA0 + rr[i]));
      tick();
      #1;
      chk("rr_idle_busy",  64'(busy),      64'd0);
      chk("rr_idle_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 4'b0000;

    // Move pointer to 0 with one single-beat grant to requester 0
    in_valid = 4'b0001;
    tick();
    #1;
    chk("prep_src0", 64'(out_src), 64'd0);
    tick();

    // Burst lock: req1 three beats while req0 and req2 wait
    in_valid = 4'b0111;
    in_last  = 4'b0101;
    set_lane(1, 32'h100);
    tick();
    #1;
    chk("bl_src_b1",      64'(out_src),  64'd1);
    chk("bl_data_b1",     64'(out_data), 64'h100);
    chk("bl_in_ready_b1", 64'(in_ready), 64'b0010);
    chk("bl_last_b1",     64'(out_last), 64'd0);
    tick();
    set_lane(1, 32'h101);
    #1;
    chk("bl_src_b2",  64'(out_src),  64'd1);
    chk("bl_data_b2", 64'(out_data), 64'h101);
    tick();
    set_lane(1, 32'h102);
    in_last[1] = 1'b1;
    #1;
    chk("bl_src_b3",  64'(out_src),  64'd1);
    chk("bl_last_b3", 64'(out_last), 64'd1);
    chk("bl_data_b3", 64'(out_data), 64'h102);
    tick();
    in_valid = 4'b0101;
    #1;
    chk("bl_idle_busy", 64'(busy), 64'd0);
    tick();
    #1;
    chk("bl_next_src2", 64'(out_src), 64'd2);
    tick();
    in_valid = 4'b0000;
    #1;
    chk("bl_end_busy", 64'(busy), 64'd0);

    // Fairness cap: req2 never sends last, forced release after 4 beats, then req3
    in_valid = 4'b0100;
    in_last  = 4'b1000;
    tick();
    in_valid = 4'b1100;
    for (int b = 0; b < MB; b++) begin
      #1;
      chk("cap_src",  64'(out_src),  64'd2);
      chk("cap_last", 64'(out_last), 64'd0);
      chk("cap_busy", 64'(busy),     64'd1);
      tick();
    end
    #1;
    chk("cap_idle_busy",  64'(busy),      64'd0);
    chk("cap_idle_valid", 64'(out_valid), 64'd0);
    tick();
    #1;
    chk("cap_next_src3", 64'(out_src), 64'd3);
    tick();
    in_valid = 4'b0000;
    in_last  = 4'b0000;

    // Backpressure: 5 stalled cycles on beat 2 of a 4-beat burst from req0
    set_lane(0, 32'h200);
    in_valid = 4'b0001;
    tick();
    #1;
    chk("bp_data_b1", 64'(out_data), 64'h200);
    tick();
    set_lane(0, 32'h201);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_stall_data",     64'(out_data), 64'h201);
      chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stall_busy",     64'(busy),     64'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_in_ready", 64'(in_ready), 64'b0001);
    chk("bp_resume_data",     64'(out_data), 64'h201);
    tick();
    set_lane(0, 32'h202);
    #1;
    chk("bp_busy_b3", 64'(busy),     64'd1);
    chk("bp_data_b3", 64'(out_data), 64'h202);
    tick();
    set_lane(0, 32'h203);
    in_last = 4'b0001;
    #1;
    chk("bp_busy_b4", 64'(busy),     64'd1);
    chk("bp_last_b4", 64'(out_last), 64'd1);
    tick();
    #1;
    chk("bp_end_busy", 64'(busy), 64'd0);

    // Mid-burst reset from req3, then req0 wins after reset
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    set_lane(3, 32'h300);
    tick();
    #1;
    chk("mr_src3", 64'(out_src), 64'd3);
    tick();
    rst_n = 1'b0;
    tick();
    #1;
    chk("mr_busy",     64'(busy),      64'd0);
    chk("mr_valid",    64'(out_valid), 64'd0);
    chk("mr_src",      64'(out_src),   64'd0);
    chk("mr_in_ready", 64'(in_ready),  64'd0);
    rst_n    = 1'b1;
    in_valid = 4'b1001;
    tick();
    #1;
    chk("mr_after_src0",  64'(out_src),  64'd0);
    chk("mr_after_data0", 64'(out_data), 64'h203);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
